// File: rtl/cpu_ctrl_fsm_hs.sv
// Multi-cycle CPU control FSM with mem_req/mem_ready handshake, bus-timeout
// watchdog, decode stall and halt/resume.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   itype, wb      : instruction class (0=R,1=I,2=P,3=J) and write-back/store flag
//   mem_ready      : memory handshake complete this cycle
//   stall          : hold in DECODE (operand hazard)
//   halt_req       : enter HALT from DECODE
//   resume         : leave HALT, re-dispatch the held instruction
//   mem_req .. link_sel : datapath / memory control strobes
//   halted, bus_err     : status (bus_err is sticky until reset)
//
// Optional feature: define CPU_FSM_IRQ_EN to add the irq input and irq_ack
// output; an IRQ state is then taken at instruction end while irq is high.
module cpu_ctrl_fsm_hs #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5,
    parameter int TYPE_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TYPE_W-1:0] itype,
    input  logic              wb,
    input  logic              mem_ready,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              resume,
`ifdef CPU_FSM_IRQ_EN
    input  logic              irq,
    output logic              irq_ack,
`endif
    output logic              mem_req,
    output logic              pc_en,
    output logic              ls_cntl,
    output logic              mem_we,
    output logic              ir_en,
    output logic              imm_sel,
    output logic              reg_wen,
    output logic              flags_en,
    output logic              mem_to_bus,
    output logic              npc_sel,
    output logic              link_sel,
    output logic              halted,
    output logic              bus_err
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_ACC  = 4'd4,
        S_MEM_DONE = 4'd5,
        S_JLINK    = 4'd6,
        S_JLOAD    = 4'd7,
        S_JDONE    = 4'd8,
        S_HALT     = 4'd9,
        S_ERR      = 4'd10,
        S_IRQ      = 4'd11
    } state_t;

    localparam logic [TYPE_W-1:0] T_I = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] T_P = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_J = TYPE_W'(3);

    // Last tolerated wait count before the watchdog fires.
    localparam logic [TO_W-1:0] TO_LIMIT =
        TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t          r_state;
    state_t          w_next;
    logic [TO_W-1:0] r_wait_cnt;
    logic            w_waiting;
    logic            w_to_hit;
    logic            w_is_i;
    state_t          w_end_next;

    assign w_is_i    = (itype == T_I);
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_ACC))
                       && !mem_ready;
    // A ready on the limit cycle wins, since w_waiting needs !mem_ready.
    assign w_to_hit  = (TIMEOUT != 0) && w_waiting
                       && (r_wait_cnt == TO_LIMIT);

`ifdef CPU_FSM_IRQ_EN
    assign w_end_next = irq ? S_IRQ : S_FETCH;
`else
    assign w_end_next = S_FETCH;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_waiting)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)
                    w_next = S_DECODE;
                else if (w_to_hit)
                    w_next = S_ERR;
            end
            S_DECODE: begin
                if (stall)
                    w_next = S_DECODE;
                else if (halt_req)
                    w_next = S_HALT;
                else if (itype == T_P)
                    w_next = S_MEM_ADDR;
                else if (itype == T_J)
                    w_next = S_JLINK;
                else
                    w_next = S_EXEC;
            end
            S_EXEC:     w_next = w_end_next;
            S_MEM_ADDR: w_next = S_MEM_ACC;
            S_MEM_ACC: begin
                if (mem_ready)
                    w_next = S_MEM_DONE;
                else if (w_to_hit)
                    w_next = S_ERR;
            end
            S_MEM_DONE: w_next = w_end_next;
            S_JLINK:    w_next = S_JLOAD;
            S_JLOAD:    w_next = S_JDONE;
            S_JDONE:    w_next = w_end_next;
            S_HALT: begin
                if (resume)
                    w_next = S_DECODE;
            end
            S_ERR:      w_next = S_ERR;
`ifdef CPU_FSM_IRQ_EN
            S_IRQ:      w_next = S_FETCH;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        pc_en      = 1'b0;
        ls_cntl    = 1'b0;
        mem_we     = 1'b0;
        ir_en      = 1'b0;
        imm_sel    = 1'b0;
        reg_wen    = 1'b0;
        flags_en   = 1'b0;
        mem_to_bus = 1'b0;
        npc_sel    = 1'b0;
        link_sel   = 1'b0;
        halted     = 1'b0;
        bus_err    = 1'b0;
`ifdef CPU_FSM_IRQ_EN
        irq_ack    = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ls_cntl = 1'b1;
                ir_en   = mem_ready;
            end
            S_DECODE: imm_sel = w_is_i;
            S_EXEC: begin
                pc_en    = 1'b1;
                flags_en = 1'b1;
                reg_wen  = wb;
                imm_sel  = w_is_i;
            end
            S_MEM_ACC: begin
                mem_req    = 1'b1;
                mem_we     = wb;
                reg_wen    = !wb && mem_ready;
                mem_to_bus = !wb;
            end
            S_MEM_DONE: pc_en = 1'b1;
            S_JLINK: begin
                pc_en      = 1'b1;
                npc_sel    = 1'b1;
                reg_wen    = wb;
                mem_to_bus = wb;
                link_sel   = wb;
            end
            S_JLOAD: npc_sel = 1'b1;
            S_JDONE: pc_en   = 1'b1;
            S_HALT:  halted  = 1'b1;
            S_ERR:   bus_err = 1'b1;
`ifdef CPU_FSM_IRQ_EN
            S_IRQ: begin
                irq_ack    = 1'b1;
                reg_wen    = 1'b1;
                link_sel   = 1'b1;
                mem_to_bus = 1'b1;
                npc_sel    = 1'b1;
                pc_en      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm_hs.sv
// Randomized scoreboard bench for cpu_ctrl_fsm_hs (default build).
// Driver steps a phase-level model and queues expected outputs; monitor checks.
module tb_cpu_ctrl_fsm_hs;

    localparam int TO = 4;
    localparam int NCYC = 4000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] itype;
    logic       wb, mem_ready, stall, halt_req, resume;
    logic       mem_req, pc_en, ls_cntl, mem_we, ir_en, imm_sel;
    logic       reg_wen, flags_en, mem_to_bus, npc_sel, link_sel;
    logic       halted, bus_err;

    int total = 0;
    int bad   = 0;

    logic [12:0] exp_q[$];
    int          cyc_q[$];

    cpu_ctrl_fsm_hs #(.TIMEOUT(TO), .TO_W(5), .TYPE_W(2)) dut (
        .clk(clk), .reset(reset), .itype(itype), .wb(wb),
        .mem_ready(mem_ready), .stall(stall), .halt_req(halt_req),
        .resume(resume), .mem_req(mem_req), .pc_en(pc_en),
        .ls_cntl(ls_cntl), .mem_we(mem_we), .ir_en(ir_en),
        .imm_sel(imm_sel), .reg_wen(reg_wen), .flags_en(flags_en),
        .mem_to_bus(mem_to_bus), .npc_sel(npc_sel), .link_sel(link_sel),
        .halted(halted), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Expected strobes for a phase, straight from the control table.
    function automatic logic [12:0] expect_out(string ph, logic [1:0] t,
                                               logic w, logic mr);
        logic rq, pc, ls, we, ir, im, rw, fl, mb, np, lk, hl, be;
        {rq, pc, ls, we, ir, im, rw, fl, mb, np, lk, hl, be} = '0;
        if (ph == "fetch") begin
            rq = 1; ls = 1; ir = mr;
        end else if (ph == "decode") begin
            im = (t == 2'd1);
        end else if (ph == "exec") begin
            pc = 1; fl = 1; rw = w; im = (t == 2'd1);
        end else if (ph == "macc") begin
            rq = 1; we = w; rw = !w && mr; mb = !w;
        end else if (ph == "mdone" || ph == "jdone") begin
            pc = 1;
        end else if (ph == "jlink") begin
            pc = 1; np = 1; rw = w; mb = w; lk = w;
        end else if (ph == "jload") begin
            np = 1;
        end else if (ph == "halt") begin
            hl = 1;
        end else if (ph == "err") begin
            be = 1;
        end
        return {rq, pc, ls, we, ir, im, rw, fl, mb, np, lk, hl, be};
    endfunction

    string ph = "none";
    int    waited = 0;
    int    mode = 7;
    int    errc = 0;

    // Advance the model over the edge that just sampled the current inputs.
    task automatic model_step();
        string nx;
        nx = ph;
        if (reset) begin
            nx = "fetch";
        end else if (ph == "fetch" || ph == "macc") begin
            if (mem_ready)
                nx = (ph == "fetch") ? "decode" : "mdone";
            else if (waited + 1 == TO)
                nx = "err";
            else
                waited++;
        end else if (ph == "decode") begin
            if (stall)         nx = "decode";
            else if (halt_req) nx = "halt";
            else if (itype == 2'd2) nx = "maddr";
            else if (itype == 2'd3) nx = "jlink";
            else                    nx = "exec";
        end else if (ph == "halt") begin
            if (resume) nx = "decode";
        end else if (ph == "exec" || ph == "mdone" || ph == "jdone") begin
            nx = "fetch";
        end else if (ph == "maddr") begin
            nx = "macc";
        end else if (ph == "jlink") begin
            nx = "jload";
        end else if (ph == "jload") begin
            nx = "jdone";
        end
        if (nx != ph || reset) begin
            waited = 0;
            if (nx == "fetch")
                mode = $urandom_range(0, 9);
        end
        errc = (nx == "err") ? errc + 1 : 0;
        ph = nx;
    endtask

    initial begin
        reset = 1; itype = 0; wb = 0; mem_ready = 0;
        stall = 0; halt_req = 0; resume = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            model_step();
            reset = (c < 2) || (errc >= 3) || ($urandom_range(0, 150) == 0);
            if (ph == "fetch") begin
                itype = 2'($urandom);
                wb    = 1'($urandom);
            end
            if (mode == 0)      mem_ready = 0;
            else if (mode < 4)  mem_ready = 1'($urandom);
            else                mem_ready = 1;
            stall    = ($urandom_range(0, 3) == 0);
            halt_req = ($urandom_range(0, 4) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            exp_q.push_back(expect_out(ph, itype, wb, mem_ready));
            cyc_q.push_back(c);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, need 0",
                     exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [12:0] e, a;
        int c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                a = {mem_req, pc_en, ls_cntl, mem_we, ir_en, imm_sel,
                     reg_wen, flags_en, mem_to_bus, npc_sel, link_sel,
                     halted, bus_err};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outs cyc=%0d got=%b want=%b", c, a, e);
                end
            end
        end
    end

endmodule
